gpio_in_conditioner: RTL
========================

Name: gpio_in_conditioner

Overview:
Input-side conditioning stage that drives the 17-bit GPIOIN bus of the parity-protected AHB GPIO peripheral.
- Synchronises 16 raw asynchronous pins and debounces them as a whole word.
- Appends a registered parity bit in MSB, using the same PARITYSEL convention as the GPIO: 1 = odd, 0 = even.
- Provides change pulse, busy flag and commit counter for software/debug, plus a parity-error injection hook for verification.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops per pin (legal 2..4)
DEBOUNCE_CYCLES, 4, consecutive cycles the synchronised word must be stable before commit (legal 1..255)

Ports:
HCLK  input  1  clock
HRESET  input  1  reset; one clock, reset is synchronous and active-high
PINS  input  16  raw asynchronous pin levels
PARITYSEL  input  1  1 = odd parity, 0 = even parity
DBEN  input  1  1 = debounce enabled, 0 = bypass (commit every cycle)
ERRINJ  input  1  invert parity bit of the word committed this cycle
GPIOIN  output  17  [15:0] debounced data, [16] parity bit
GPIOCHG  output  1  one-cycle pulse, asserted in the same cycle a new value appears on GPIOIN[15:0]
BUSY  output  1  high while in SETTLE
CHGCOUNT  output  8  saturating count of commits with changed data

Behaviour:
- Synchroniser: SYNC_STAGES-deep flop chain per pin; its last stage is s[15:0].
- Reset (HRESET high at posedge HCLK) clears everything: sync chain, candidate, counter, inj_flag all 0; state STABLE; GPIOIN = 17'h0; GPIOCHG, BUSY, CHGCOUNT = 0.
- Parity register, every cycle: GPIOIN[16] <= (^next_data) ^ PARITYSEL ^ next_inj_flag.
  - First edge after reset release gives GPIOIN[16] = PARITYSEL.
  - A PARITYSEL change is reflected 1 cycle later.
- inj_flag: set to ERRINJ on every commit; holds between commits. ERRINJ outside a commit cycle is ignored.
- FSM (DBEN = 1), state values STABLE = 0, SETTLE = 1:
  - STABLE, s == GPIOIN[15:0]: stay, no action.
  - STABLE, s != GPIOIN[15:0]: candidate <= s, cnt <= 1, go SETTLE. If DEBOUNCE_CYCLES == 1, commit immediately and stay STABLE.
  - SETTLE, s == GPIOIN[15:0] (bounce back): cnt <= 0, go STABLE, no commit.
  - SETTLE, s != candidate (and != data): candidate <= s, cnt <= 1 (restart).
  - SETTLE, s == candidate, cnt == DEBOUNCE_CYCLES-1: commit, go STABLE.
  - SETTLE, s == candidate, otherwise: cnt++.
- Commit (registered, single edge):
  - GPIOIN[15:0] <= candidate (or s in the immediate cases); GPIOCHG <= 1; CHGCOUNT <= min(CHGCOUNT+1, 255); parity per rule above.
  - GPIOCHG is 0 on all non-commit cycles.
- Latency: pin change held stable -> GPIOIN update after exactly SYNC_STAGES + DEBOUNCE_CYCLES posedges (default 6).
- Bypass (DBEN = 0): state forced STABLE, cnt = 0. Commit whenever s != GPIOIN[15:0]; latency SYNC_STAGES + 1.
- DBEN dropped while in SETTLE: abandon candidate, go STABLE; bypass rule applies on the same edge.
- CHGCOUNT saturates at 255 and never wraps; cleared only by reset.
- Reset mid-SETTLE: candidate discarded, no commit, no GPIOCHG.
- BUSY = (state == SETTLE), registered with the state.

Test Plan:
- Reset then hold PINS = 16'h0000, PARITYSEL = 1 -> GPIOIN = 17'h10000 one edge after reset release; GPIOCHG never pulses; CHGCOUNT = 0.
- Step PINS to 16'hA5A5 (8 ones), PARITYSEL = 0, defaults -> GPIOIN = 17'h0A5A5 exactly 6 edges after the step; GPIOCHG high one cycle; CHGCOUNT = 1. Then toggle PARITYSEL to 1 -> GPIOIN = 17'h1A5A5 one edge later, no GPIOCHG.
- Bounce: PINS 0000 -> 0001 for 2 cycles -> 0000 -> GPIOIN stays 0, BUSY high 2 cycles, no commit. Then 0001 for 2 cycles, 0003 held -> commit 0003 only after 4 stable cycles of 0003.
- ERRINJ = 1 on commit of 16'h0007, PARITYSEL = 0 -> GPIOIN[16] = 0 (correct value 1 inverted), held until the next commit with ERRINJ = 0 restores correct parity.
- DBEN = 0, PINS alternating 16'h0001 / 16'h0002 each cycle -> GPIOIN follows with 3-cycle lag; GPIOCHG every cycle; CHGCOUNT reaches 255 after 255 commits and stays there.
- Assert HRESET for one cycle while in SETTLE with cnt = 3 -> all outputs 0 next edge; no commit of the pending candidate.

Source files
------------

// File: rtl/gpio_in_conditioner_if.sv
// Pin-side and GPIOIN-side signal bundle of the GPIO input conditioner.
// The master drives the raw pins and controls; the slave produces the conditioned word.
interface gpio_in_conditioner_if;
  logic [15:0] PINS;
  logic        PARITYSEL;
  logic        DBEN;
  logic        ERRINJ;
  logic [16:0] GPIOIN;
  logic        GPIOCHG;
  logic        BUSY;
  logic [7:0]  CHGCOUNT;

  modport master (
    output PINS, PARITYSEL, DBEN, ERRINJ,
    input  GPIOIN, GPIOCHG, BUSY, CHGCOUNT
  );

  modport slave (
    input  PINS, PARITYSEL, DBEN, ERRINJ,
    output GPIOIN, GPIOCHG, BUSY, CHGCOUNT
  );
endinterface

// File: rtl/gpio_in_conditioner.sv
// Synchronises and word-debounces 16 raw pins, then presents them with a registered
// parity bit (odd/even selectable, optional error injection) on the 17-bit GPIOIN bus.
module gpio_in_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  gpio_in_conditioner_if.slave   gpio
);

  typedef enum logic {
    STABLE = 1'b0,
    SETTLE = 1'b1
  } state_t;

  localparam logic [7:0] LAST_CNT = 8'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0][15:0] sync_reg;
  logic [15:0] s;

  state_t      state_reg, state_next;
  logic [15:0] cand_reg, cand_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic [15:0] data_reg, data_next;
  logic        inj_reg, inj_next;
  logic        par_reg;
  logic        chg_reg;
  logic [7:0]  count_reg, count_next;
  logic        commit;
  logic [15:0] commit_data;

  assign s = sync_reg[SYNC_STAGES-1];

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], gpio.PINS};
    end
  end

  always_comb begin
    state_next  = state_reg;
    cand_next   = cand_reg;
    cnt_next    = cnt_reg;
    commit      = 1'b0;
    commit_data = cand_reg;

    if (!gpio.DBEN) begin
      // Bypass also abandons any candidate being settled.
      state_next = STABLE;
      cnt_next   = 8'd0;
      if (s != data_reg) begin
        commit      = 1'b1;
        commit_data = s;
      end
    end else begin
      case (state_reg)
        STABLE: begin
          if (s != data_reg) begin
            if (DEBOUNCE_CYCLES == 1) begin
              commit      = 1'b1;
              commit_data = s;
            end else begin
              cand_next  = s;
              cnt_next   = 8'd1;
              state_next = SETTLE;
            end
          end
        end
        SETTLE: begin
          if (s == data_reg) begin
            cnt_next   = 8'd0;
            state_next = STABLE;
          end else if (s != cand_reg) begin
            cand_next = s;
            cnt_next  = 8'd1;
          end else if (cnt_reg == LAST_CNT) begin
            commit      = 1'b1;
            commit_data = cand_reg;
            cnt_next    = 8'd0;
            state_next  = STABLE;
          end else begin
            cnt_next = cnt_reg + 8'd1;
          end
        end
        default: begin
          state_next = STABLE;
          cnt_next   = 8'd0;
        end
      endcase
    end

    data_next  = commit ? commit_data : data_reg;
    inj_next   = commit ? gpio.ERRINJ : inj_reg;
    count_next = (commit && count_reg != 8'hFF) ? count_reg + 8'd1 : count_reg;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_reg <= STABLE;
      cand_reg  <= '0;
      cnt_reg   <= '0;
      data_reg  <= '0;
      inj_reg   <= 1'b0;
      par_reg   <= 1'b0;
      chg_reg   <= 1'b0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      cand_reg  <= cand_next;
      cnt_reg   <= cnt_next;
      data_reg  <= data_next;
      inj_reg   <= inj_next;
      // Parity tracks PARITYSEL every cycle, not only on commits.
      par_reg   <= (^data_next) ^ gpio.PARITYSEL ^ inj_next;
      chg_reg   <= commit;
      count_reg <= count_next;
    end
  end

  assign gpio.GPIOIN   = {par_reg, data_reg};
  assign gpio.GPIOCHG  = chg_reg;
  assign gpio.BUSY     = (state_reg == SETTLE);
  assign gpio.CHGCOUNT = count_reg;

endmodule
